// File: rtl/dds_frame_pkg.sv
// Constants, state encoding and checksum helper shared by the UART frame transmitter
// and the command receiver.
package dds_frame_pkg;

  localparam logic [7:0] FRAME_HEAD = 8'h55;
  localparam logic [7:0] FRAME_TAIL = 8'hAA;
  localparam int         FRAME_LEN  = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_GAP
  } frame_state_t;

  // XOR of frame bytes 1..11; byte 1 sits in body[87:80], byte 11 in body[7:0].
  function automatic logic [7:0] frame_chk(input logic [87:0] body);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < 11; i++) begin
      acc ^= body[i*8 +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer with optional trailing mark (gap) bit-times. A new byte offered
// during the last cycle of the final mark bit starts without any idle cycle.
module uart_byte_tx
  import dds_frame_pkg::*;
#(
  parameter int BAUD_CNT = 434,
  parameter int GAP_BITS = 0
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       i_byte_valid,
  input  logic [7:0] i_byte_data,
  output logic       o_byte_ready,
  output logic       o_txd
);

  localparam int             CW        = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
  localparam logic [CW-1:0]  BAUD_LAST = CW'(BAUD_CNT - 1);
  localparam logic [3:0]     GAP_LAST  = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;

  frame_state_t  r_state, w_state_next;
  logic [CW-1:0] r_baud_cnt, w_baud_cnt_next;
  logic [2:0]    r_bit_idx, w_bit_idx_next;
  logic [3:0]    r_gap_cnt, w_gap_cnt_next;
  logic [7:0]    r_data, w_data_next;
  logic          r_txd, w_txd_next;
  logic          w_bit_end;
  logic          w_last_mark;

  assign w_bit_end    = (r_baud_cnt == BAUD_LAST);
  assign w_last_mark  = w_bit_end &&
                        (((r_state == ST_STOP) && (GAP_BITS == 0)) ||
                         ((r_state == ST_GAP) && (r_gap_cnt == GAP_LAST)));
  assign o_byte_ready = (r_state == ST_IDLE) || w_last_mark;
  assign o_txd        = r_txd;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_state    <= ST_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_gap_cnt  <= '0;
      r_data     <= '0;
      r_txd      <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_baud_cnt <= w_baud_cnt_next;
      r_bit_idx  <= w_bit_idx_next;
      r_gap_cnt  <= w_gap_cnt_next;
      r_data     <= w_data_next;
      r_txd      <= w_txd_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_baud_cnt_next = w_bit_end ? '0 : r_baud_cnt + 1'b1;
    w_bit_idx_next  = r_bit_idx;
    w_gap_cnt_next  = r_gap_cnt;
    w_data_next     = r_data;
    w_txd_next      = 1'b1;

    case (r_state)
      ST_IDLE: begin
        w_baud_cnt_next = '0;
        if (i_byte_valid) begin
          w_state_next = ST_START;
          w_data_next  = i_byte_data;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_next   = ST_DATA;
          w_bit_idx_next = '0;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) w_state_next = ST_STOP;
          else                   w_bit_idx_next = r_bit_idx + 1'b1;
        end
      end
      ST_STOP: begin
        if (w_bit_end && (GAP_BITS > 0)) begin
          w_state_next   = ST_GAP;
          w_gap_cnt_next = '0;
        end
      end
      ST_GAP: begin
        if (w_bit_end && !w_last_mark) w_gap_cnt_next = r_gap_cnt + 1'b1;
      end
      default: w_state_next = ST_IDLE;
    endcase

    // End of the final mark bit: chain straight into the next start bit if one is waiting.
    if (w_last_mark) begin
      if (i_byte_valid) begin
        w_state_next = ST_START;
        w_data_next  = i_byte_data;
      end else begin
        w_state_next = ST_IDLE;
      end
    end

    case (w_state_next)
      ST_START: w_txd_next = 1'b0;
      ST_DATA:  w_txd_next = w_data_next[w_bit_idx_next];
      default:  w_txd_next = 1'b1;
    endcase
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Captures one status record, builds the 14-byte response frame (head, 11 payload bytes,
// XOR checksum, tail) and streams it through the byte serializer back to back.
module uart_frame_tx
  import dds_frame_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 115200,
  parameter int GAP_BITS = 0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [7:0]  reg_func,
  input  logic [7:0]  hs_pwm_ch,
  input  logic [7:0]  hs_ctrl_sta,
  input  logic [7:0]  duty_num,
  input  logic [15:0] pulse_dessert,
  input  logic [7:0]  pulse_num,
  input  logic [31:0] pat,
  output logic        uart_txd,
  output logic        tx_busy,
  output logic        frame_done
);

  localparam int         BAUD_CNT = CLK_FREQ / UART_BPS;
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  logic       r_busy;
  logic       r_done;
  logic [3:0] r_byte_idx;
  logic [3:0] w_next_idx;
  logic [7:0] r_frame [FRAME_LEN];
  logic [7:0] w_in_bytes [FRAME_LEN];
  logic       w_accept;
  logic       w_byte_valid;
  logic       w_byte_ready;
  logic [7:0] w_byte_data;

  assign frame_ready  = !r_busy && !sys_rst;
  assign w_accept     = frame_valid && frame_ready;
  assign w_next_idx   = (r_byte_idx == LAST_IDX) ? LAST_IDX : r_byte_idx + 4'd1;
  // The head byte goes straight from the accept edge so the start bit follows immediately.
  assign w_byte_valid = r_busy ? (r_byte_idx != LAST_IDX) : w_accept;
  assign w_byte_data  = r_busy ? r_frame[w_next_idx] : FRAME_HEAD;
  assign tx_busy      = r_busy;
  assign frame_done   = r_done;

  always_comb begin
    w_in_bytes[0]  = FRAME_HEAD;
    w_in_bytes[1]  = reg_func;
    w_in_bytes[2]  = hs_pwm_ch;
    w_in_bytes[3]  = hs_ctrl_sta;
    w_in_bytes[4]  = duty_num;
    w_in_bytes[5]  = pulse_dessert[15:8];
    w_in_bytes[6]  = pulse_dessert[7:0];
    w_in_bytes[7]  = pulse_num;
    w_in_bytes[8]  = pat[31:24];
    w_in_bytes[9]  = pat[23:16];
    w_in_bytes[10] = pat[15:8];
    w_in_bytes[11] = pat[7:0];
    w_in_bytes[12] = frame_chk({reg_func, hs_pwm_ch, hs_ctrl_sta, duty_num,
                                pulse_dessert, pulse_num, pat});
    w_in_bytes[13] = FRAME_TAIL;
  end

  always_ff @(posedge sys_clk) begin
    if (w_accept) begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        r_frame[i] <= w_in_bytes[i];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_byte_idx <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_busy     <= 1'b1;
        r_byte_idx <= '0;
      end else if (r_busy && w_byte_ready) begin
        if (r_byte_idx == LAST_IDX) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_byte_idx <= w_next_idx;
        end
      end
    end
  end

  uart_byte_tx #(
    .BAUD_CNT (BAUD_CNT),
    .GAP_BITS (GAP_BITS)
  ) u_byte_tx (
    .clk          (sys_clk),
    .srst         (sys_rst),
    .i_byte_valid (w_byte_valid),
    .i_byte_data  (w_byte_data),
    .o_byte_ready (w_byte_ready),
    .o_txd        (uart_txd)
  );

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: a 16-cycle bit-time instance without gap and one with
// two gap bits, decoded by a mid-bit sampling receiver with hand-computed frames.
module tb_uart_frame_tx;

  localparam int CLK_FREQ = 1_600_000;
  localparam int UART_BPS = 100_000;
  localparam int B        = CLK_FREQ / UART_BPS;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        valid_a = 1'b0;
  logic        valid_g = 1'b0;
  logic [7:0]  reg_func = '0, hs_pwm_ch = '0, hs_ctrl_sta = '0, duty_num = '0, pulse_num = '0;
  logic [15:0] pulse_dessert = '0;
  logic [31:0] pat = '0;
  logic        ready_a, txd_a, busy_a, done_a;
  logic        ready_g, txd_g, busy_g, done_g;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] e_t2 [14] = '{8'h55, 8'h01, 8'h01, 8'h01, 8'h03, 8'h00, 8'h44,
                            8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hB9, 8'hAA};
  logic [7:0] e_t3 [14] = '{8'h55, 8'h01, 8'h01, 8'h01, 8'hFF, 8'h07, 8'h30,
                            8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC9, 8'hAA};
  logic [7:0] e_a  [14] = '{8'h55, 8'hA5, 8'h02, 8'h80, 8'h10, 8'h12, 8'h34,
                            8'h07, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h34, 8'hAA};
  logic [7:0] e_b  [14] = '{8'h55, 8'h3C, 8'h00, 8'hFF, 8'h7F, 8'h80, 8'h01,
                            8'h00, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h3D, 8'hAA};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_frame_tx #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .GAP_BITS(0)) dut_a (
    .sys_clk(clk), .sys_rst(sys_rst), .frame_valid(valid_a), .frame_ready(ready_a),
    .reg_func(reg_func), .hs_pwm_ch(hs_pwm_ch), .hs_ctrl_sta(hs_ctrl_sta), .duty_num(duty_num),
    .pulse_dessert(pulse_dessert), .pulse_num(pulse_num), .pat(pat),
    .uart_txd(txd_a), .tx_busy(busy_a), .frame_done(done_a));

  uart_frame_tx #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .GAP_BITS(2)) dut_g (
    .sys_clk(clk), .sys_rst(sys_rst), .frame_valid(valid_g), .frame_ready(ready_g),
    .reg_func(reg_func), .hs_pwm_ch(hs_pwm_ch), .hs_ctrl_sta(hs_ctrl_sta), .duty_num(duty_num),
    .pulse_dessert(pulse_dessert), .pulse_num(pulse_num), .pat(pat),
    .uart_txd(txd_g), .tx_busy(busy_g), .frame_done(done_g));

  function automatic logic get_txd(input int sel);
    return (sel != 0) ? txd_g : txd_a;
  endfunction
  function automatic logic get_done(input int sel);
    return (sel != 0) ? done_g : done_a;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel != 0) ? busy_g : busy_a;
  endfunction
  function automatic logic get_ready(input int sel);
    return (sel != 0) ? ready_g : ready_a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input logic [7:0] f, input logic [7:0] ch, input logic [7:0] st,
                            input logic [7:0] du, input logic [15:0] pd, input logic [7:0] pn,
                            input logic [31:0] pt);
    reg_func = f; hs_pwm_ch = ch; hs_ctrl_sta = st; duty_num = du;
    pulse_dessert = pd; pulse_num = pn; pat = pt;
  endtask

  // Raise valid at a negedge; at the next negedge the accept edge has passed.
  task automatic send(input int sel, input string tag);
    check({tag, " ready_before"}, 32'(get_ready(sel)), 32'd1);
    if (sel != 0) valid_g = 1'b1; else valid_a = 1'b1;
    @(negedge clk);
    check({tag, " busy_after_accept"}, 32'(get_busy(sel)), 32'd1);
    check({tag, " start_latency"}, 32'(get_txd(sel)), 32'd0);
    check({tag, " ready_while_busy"}, 32'(get_ready(sel)), 32'd0);
  endtask

  // Call at the negedge of the first start-bit cycle; returns one cycle after frame_done.
  task automatic rx_frame(input int sel, input logic [7:0] exp [14], input int gap, input string tag);
    int t_first, t_prev, t_start, w;
    logic [7:0] b;
    t_first = 0;
    t_prev  = 0;
    for (int k = 0; k < 14; k++) begin
      w = 0;
      while (get_txd(sel) !== 1'b0 && w < 4 * B) begin
        @(negedge clk);
        w++;
      end
      check($sformatf("%s byte%0d start_found", tag, k), 32'(w < 4 * B), 32'd1);
      t_start = cyc;
      if (k == 0) t_first = t_start;
      else check($sformatf("%s byte%0d period", tag, k), 32'(t_start - t_prev), 32'((10 + gap) * B));
      t_prev = t_start;
      repeat (B / 2) @(negedge clk);
      check($sformatf("%s byte%0d start_bit", tag, k), 32'(get_txd(sel)), 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (B) @(negedge clk);
        b[i] = get_txd(sel);
      end
      repeat (B) @(negedge clk);
      check($sformatf("%s byte%0d stop_bit", tag, k), 32'(get_txd(sel)), 32'd1);
      check($sformatf("%s byte%0d data", tag, k), 32'(b), 32'(exp[k]));
    end
    w = 0;
    while (get_done(sel) !== 1'b1 && w < 4 * B) begin
      @(negedge clk);
      w++;
    end
    check({tag, " done_found"}, 32'(w < 4 * B), 32'd1);
    check({tag, " frame_cycles"}, 32'(cyc - t_first), 32'(14 * (10 + gap) * B));
    check({tag, " busy_at_done"}, 32'(get_busy(sel)), 32'd0);
    check({tag, " ready_at_done"}, 32'(get_ready(sel)), 32'd1);
    @(negedge clk);
    check({tag, " done_one_cycle"}, 32'(get_done(sel)), 32'd0);
    $display("frame %s received, %0d cycles", tag, cyc - 1 - t_first);
  endtask

  initial begin : stim
    int seen_done;
    int seen_low;

    // T1: reset behaviour
    repeat (5) @(negedge clk);
    check("T1 txd_in_reset", 32'(txd_a), 32'd1);
    check("T1 busy_in_reset", 32'(busy_a), 32'd0);
    check("T1 ready_in_reset", 32'(ready_a), 32'd0);
    check("T1 done_in_reset", 32'(done_a), 32'd0);
    check("T1 gap_txd_in_reset", 32'(txd_g), 32'd1);
    sys_rst = 1'b0;
    @(negedge clk);
    check("T1 ready_after_release", 32'(ready_a), 32'd1);
    check("T1 gap_ready_after_release", 32'(ready_g), 32'd1);
    check("T1 txd_idle", 32'(txd_a), 32'd1);
    $display("reset sequence complete");

    // T2: single frame
    set_fields(8'h01, 8'h01, 8'h01, 8'h03, 16'h0044, 8'h00, 32'h0000_00FF);
    send(0, "T2");
    valid_a = 1'b0;
    rx_frame(0, e_t2, 0, "T2");

    // T3: checksum with saturated fields
    repeat (3) @(negedge clk);
    set_fields(8'h01, 8'h01, 8'h01, 8'hFF, 16'h0730, 8'h00, 32'hFFFF_FFFF);
    send(0, "T3");
    valid_a = 1'b0;
    rx_frame(0, e_t3, 0, "T3");

    // T4: back-to-back with valid held and fields changing mid-frame
    repeat (3) @(negedge clk);
    set_fields(8'hA5, 8'h02, 8'h80, 8'h10, 16'h1234, 8'h07, 32'hDEAD_BEEF);
    send(0, "T4a");
    set_fields(8'h3C, 8'h00, 8'hFF, 8'h7F, 16'h8001, 8'h00, 32'h0F0F_0F0F);
    rx_frame(0, e_a, 0, "T4a");
    check("T4 b2b_start_after_done", 32'(txd_a), 32'd0);
    check("T4 b2b_busy", 32'(busy_a), 32'd1);
    valid_a = 1'b0;
    set_fields(8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'hFFFF, 8'hFF, 32'hFFFF_FFFF);
    rx_frame(0, e_b, 0, "T4b");

    // T5: reset during byte 6 data bits, then a clean frame
    repeat (3) @(negedge clk);
    set_fields(8'h01, 8'h01, 8'h01, 8'h03, 16'h0044, 8'h00, 32'h0000_00FF);
    send(0, "T5");
    valid_a = 1'b0;
    repeat (60 * B + 4 * B + B / 2 - 1) @(negedge clk);
    check("T5 byte6_bit3_before_reset", 32'(txd_a), 32'd0);
    sys_rst = 1'b1;
    @(negedge clk);
    check("T5 txd_after_reset", 32'(txd_a), 32'd1);
    check("T5 busy_after_reset", 32'(busy_a), 32'd0);
    check("T5 ready_in_reset", 32'(ready_a), 32'd0);
    @(negedge clk);
    sys_rst = 1'b0;
    seen_done = 0;
    seen_low  = 0;
    for (int i = 0; i < 30 * B; i++) begin
      @(negedge clk);
      if (done_a === 1'b1) seen_done++;
      if (txd_a !== 1'b1) seen_low++;
    end
    check("T5 no_frame_done", 32'(seen_done), 32'd0);
    check("T5 line_stays_idle", 32'(seen_low), 32'd0);
    $display("mid-frame reset abort observed");
    send(0, "T5r");
    valid_a = 1'b0;
    rx_frame(0, e_t2, 0, "T5r");

    // T6: two gap bits after every stop bit
    repeat (3) @(negedge clk);
    set_fields(8'hA5, 8'h02, 8'h80, 8'h10, 16'h1234, 8'h07, 32'hDEAD_BEEF);
    send(1, "T6");
    valid_g = 1'b0;
    rx_frame(1, e_a, 2, "T6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
